// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I load/store funct3 codes, the
// LSU state encoding and the byte-enable width of the data-memory port.
package load_store_unit_pkg;

    localparam int unsigned BE_W = 4;

    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;
    localparam logic [2:0] FUNCT3_SB  = 3'd0;
    localparam logic [2:0] FUNCT3_SH  = 3'd1;
    localparam logic [2:0] FUNCT3_SW  = 3'd2;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitR,
        StResp
    } lsu_state_e;

    // funct3 codes with no RV32I meaning for the given direction
    function automatic logic funct3_illegal(input logic is_load, input logic [2:0] funct3);
        if (is_load) begin
            return (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        return funct3 >= 3'd3;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic for the LSU.
// Ports:
//   funct3_i     - size/sign code
//   addr_lo_i    - byte offset within the word
//   wdata_i      - store data as supplied by execute
//   rdata_i      - raw word returned by memory
//   be_o         - byte enables for the access
//   wdata_lane_o - store data replicated into the addressed lanes
//   rdata_ext_o  - selected lane, sign- or zero-extended
//   misaligned_o - halfword/word access not naturally aligned
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [31:0]     wdata_i,
    input  logic [31:0]     rdata_i,
    output logic [BE_W-1:0] be_o,
    output logic [31:0]     wdata_lane_o,
    output logic [31:0]     rdata_ext_o,
    output logic            misaligned_o
);

    logic [31:0] lane;

    assign lane = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        be_o         = '0;
        wdata_lane_o = wdata_i;
        misaligned_o = 1'b0;
        // funct3[1:0] carries the size for both loads and stores
        unique case (funct3_i[1:0])
            2'b00: begin
                be_o         = 4'b0001 << addr_lo_i;
                wdata_lane_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_lane_o = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            2'b10: begin
                be_o         = 4'b1111;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            default: be_o = '0;
        endcase
    end

    always_comb begin
        rdata_ext_o = lane;
        case (funct3_i)
            FUNCT3_LB:  rdata_ext_o = {{24{lane[7]}}, lane[7:0]};
            FUNCT3_LBU: rdata_ext_o = {24'h0, lane[7:0]};
            FUNCT3_LH:  rdata_ext_o = {{16{lane[15]}}, lane[15:0]};
            FUNCT3_LHU: rdata_ext_o = {16'h0, lane[15:0]};
            default:    rdata_ext_o = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage between execute and writeback. Accepts one load/store per
// handshake, checks alignment/legality, issues a req/gnt/rvalid memory access and
// returns extended load data (or store completion / error) as a one-cycle pulse.
// Ports:
//   req_valid_i/req_ready_o  - op handshake from execute (ready only when idle)
//   memren_i/memwren_i       - load / store select
//   funct3_i, addr_i, wdata_i - size code, byte address, store data
//   flush_i                  - abandon an op not yet granted
//   mem_*                    - data-memory request port
//   resp_valid_o/data/err    - completion to writeback
//   busy_o                   - LSU not idle, for the hazard unit
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic              resp_valid_o,
    output logic [DWIDTH-1:0] resp_data_o,
    output logic              resp_err_o,
    output logic              busy_o
);

    lsu_state_e  state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        drop_q;     // flushed while waiting for read data

    logic        accept;
    logic        req_err;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [BE_W-1:0] al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata_ext;
    logic        al_misaligned;

    assign req_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign accept      = req_valid_i && req_ready_o && (memren_i || memwren_i);

    // The aligner sees the incoming op while idle and the captured op afterwards.
    assign al_funct3  = (state_q == StIdle) ? funct3_i    : funct3_q;
    assign al_addr_lo = (state_q == StIdle) ? addr_i[1:0] : addr_lo_q;

    load_store_unit_align u_align (
        .funct3_i     (al_funct3),
        .addr_lo_i    (al_addr_lo),
        .wdata_i      (wdata_i),
        .rdata_i      (mem_rdata_i),
        .be_o         (al_be),
        .wdata_lane_o (al_wdata),
        .rdata_ext_o  (al_rdata_ext),
        .misaligned_o (al_misaligned)
    );

    assign req_err = (memren_i && memwren_i) || funct3_illegal(memren_i, funct3_i) ||
                     al_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            drop_q       <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_be_o     <= '0;
            mem_wdata_o  <= '0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_err_o   <= 1'b0;
        end else begin
            resp_valid_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        funct3_q  <= funct3_i;
                        addr_lo_q <= addr_i[1:0];
                        drop_q    <= 1'b0;
                        if (req_err) begin
                            state_q      <= StResp;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_data_o  <= '0;
                        end else begin
                            state_q     <= StReq;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= memwren_i;
                            mem_addr_o  <= {addr_i[AWIDTH-1:2], 2'b00};
                            mem_be_o    <= al_be;
                            mem_wdata_o <= memwren_i ? al_wdata : '0;
                        end
                    end
                end
                StReq: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        if (mem_we_o) begin
                            if (flush_i) begin
                                state_q <= StIdle;
                            end else begin
                                state_q      <= StResp;
                                resp_valid_o <= 1'b1;
                                resp_err_o   <= 1'b0;
                                resp_data_o  <= '0;
                            end
                        end else if (mem_rvalid_i) begin
                            if (flush_i) begin
                                state_q <= StIdle;
                            end else begin
                                state_q      <= StResp;
                                resp_valid_o <= 1'b1;
                                resp_err_o   <= 1'b0;
                                resp_data_o  <= al_rdata_ext;
                            end
                        end else begin
                            state_q <= StWaitR;
                            drop_q  <= flush_i;
                        end
                    end else if (flush_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                StWaitR: begin
                    if (mem_rvalid_i) begin
                        if (drop_q || flush_i) begin
                            state_q <= StIdle;
                        end else begin
                            state_q      <= StResp;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b0;
                            resp_data_o  <= al_rdata_ext;
                        end
                        drop_q <= 1'b0;
                    end else if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                StResp: begin
                    resp_err_o <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        memren_i;
    logic        memwren_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .memren_i     (memren_i),
        .memwren_i    (memwren_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .busy_o       (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an op for one edge; returns at the following negedge.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid_i = 1'b1;
        memren_i    = ld;
        memwren_i   = st;
        funct3_i    = f3;
        addr_i      = a;
        wdata_i     = wd;
        @(negedge clk);
        req_valid_i = 1'b0;
        memren_i    = 1'b0;
        memwren_i   = 1'b0;
    endtask

    // Grant (optionally with read data) for one edge; returns at the next negedge.
    task automatic grant(input logic rv, input logic [31:0] rd);
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
        @(negedge clk);
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0; funct3_i = '0;
        addr_i = '0; wdata_i = '0; flush_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ready", req_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_be", mem_be_o, 0);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_resp_data", resp_data_o, 0);

        // req_valid without load/store is not accepted
        issue(1'b0, 1'b0, 3'd2, 32'h0100_0000, 32'h0);
        check("noop_busy", busy_o, 0);
        check("noop_mem_req", mem_req_o, 0);

        // SW with two wait cycles before gnt
        issue(1'b0, 1'b1, 3'd2, 32'h0100_0104, 32'hDEAD_BEEF);
        check("sw_req", mem_req_o, 1);
        check("sw_we", mem_we_o, 1);
        check("sw_addr", mem_addr_o, 32'h0100_0104);
        check("sw_be", mem_be_o, 4'b1111);
        check("sw_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        check("sw_ready0", req_ready_o, 0);
        @(negedge clk);
        check("sw_hold_req1", mem_req_o, 1);
        check("sw_ready1", req_ready_o, 0);
        @(negedge clk);
        check("sw_hold_req2", mem_req_o, 1);
        check("sw_hold_addr2", mem_addr_o, 32'h0100_0104);
        grant(1'b0, 32'h0);
        check("sw_resp_valid", resp_valid_o, 1);
        check("sw_resp_err", resp_err_o, 0);
        check("sw_req_drop", mem_req_o, 0);
        check("sw_ready_resp", req_ready_o, 0);
        @(negedge clk);
        check("sw_resp_once", resp_valid_o, 0);
        check("sw_ready_after", req_ready_o, 1);

        // LB, gnt and rvalid together
        issue(1'b1, 1'b0, 3'd0, 32'h0100_0203, 32'h0);
        check("lb_addr", mem_addr_o, 32'h0100_0200);
        check("lb_be", mem_be_o, 4'b1000);
        check("lb_we", mem_we_o, 0);
        grant(1'b1, 32'h8012_3456);
        check("lb_valid", resp_valid_o, 1);
        check("lb_data", resp_data_o, 32'hFFFF_FF80);
        @(negedge clk);
        // LBU same address/data
        issue(1'b1, 1'b0, 3'd4, 32'h0100_0203, 32'h0);
        grant(1'b1, 32'h8012_3456);
        check("lbu_valid", resp_valid_o, 1);
        check("lbu_data", resp_data_o, 32'h0000_0080);
        @(negedge clk);

        // SH lane replication, then LH
        issue(1'b0, 1'b1, 3'd1, 32'h0100_0002, 32'h0000_ABCD);
        check("sh_addr", mem_addr_o, 32'h0100_0000);
        check("sh_be", mem_be_o, 4'b1100);
        check("sh_wdata", mem_wdata_o, 32'hABCD_ABCD);
        grant(1'b0, 32'h0);
        check("sh_valid", resp_valid_o, 1);
        check("sh_data", resp_data_o, 0);
        @(negedge clk);
        issue(1'b1, 1'b0, 3'd1, 32'h0100_0002, 32'h0);
        check("lh_be", mem_be_o, 4'b1100);
        grant(1'b1, 32'h7FFF_0000);
        check("lh_data", resp_data_o, 32'h0000_7FFF);
        @(negedge clk);

        // LHU with late read data (via WAIT_R)
        issue(1'b1, 1'b0, 3'd5, 32'h0100_0006, 32'h0);
        grant(1'b0, 32'h0);
        check("lhu_wait_busy", busy_o, 1);
        check("lhu_wait_req", mem_req_o, 0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8001_1234;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        check("lhu_valid", resp_valid_o, 1);
        check("lhu_data", resp_data_o, 32'h0000_8001);
        @(negedge clk);

        // Misaligned LW: error, no memory request
        issue(1'b1, 1'b0, 3'd2, 32'h0100_0001, 32'h0);
        check("lw_mis_req", mem_req_o, 0);
        check("lw_mis_valid", resp_valid_o, 1);
        check("lw_mis_err", resp_err_o, 1);
        check("lw_mis_data", resp_data_o, 0);
        @(negedge clk);
        check("lw_mis_err_clr", resp_err_o, 0);
        // Illegal load funct3=3
        issue(1'b1, 1'b0, 3'd3, 32'h0100_0000, 32'h0);
        check("f3_ill_req", mem_req_o, 0);
        check("f3_ill_err", resp_err_o, 1);
        @(negedge clk);
        // Load and store both set
        issue(1'b1, 1'b1, 3'd2, 32'h0100_0000, 32'h0);
        check("both_err", resp_err_o, 1);
        @(negedge clk);

        // Flush in REQ before gnt
        issue(1'b1, 1'b0, 3'd2, 32'h0100_0010, 32'h0);
        check("fl_req_up", mem_req_o, 1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("fl_req_drop", mem_req_o, 0);
        check("fl_busy", busy_o, 0);
        check("fl_no_resp", resp_valid_o, 0);
        // Next op accepted: SB replicates byte
        issue(1'b0, 1'b1, 3'd0, 32'h0100_0011, 32'h0000_00A5);
        check("sb_be", mem_be_o, 4'b0010);
        check("sb_wdata", mem_wdata_o, 32'hA5A5_A5A5);
        grant(1'b0, 32'h0);
        check("sb_valid", resp_valid_o, 1);
        @(negedge clk);

        // Flush in same cycle as gnt on a store: completes, no response
        issue(1'b0, 1'b1, 3'd2, 32'h0100_0030, 32'h1111_2222);
        flush_i = 1'b1;
        grant(1'b0, 32'h0);
        flush_i = 1'b0;
        check("flgnt_no_resp", resp_valid_o, 0);
        check("flgnt_req", mem_req_o, 0);
        check("flgnt_busy", busy_o, 0);

        // Flush in WAIT_R: rvalid consumed silently, resp_data held
        issue(1'b1, 1'b0, 3'd2, 32'h0100_0020, 32'h0);
        grant(1'b0, 32'h0);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flw_busy", busy_o, 1);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        check("flw_no_resp", resp_valid_o, 0);
        check("flw_busy_done", busy_o, 0);
        check("flw_data_held", resp_data_o, 0);

        // Reset while in WAIT_R
        issue(1'b1, 1'b0, 3'd2, 32'h0100_0040, 32'h0);
        grant(1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_ready", req_ready_o, 1);
        check("mrst_req", mem_req_o, 0);
        check("mrst_addr", mem_addr_o, 0);
        check("mrst_be", mem_be_o, 0);
        check("mrst_busy", busy_o, 0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        check("stray_rv_resp", resp_valid_o, 0);
        check("stray_rv_busy", busy_o, 0);
        check("stray_rv_data", resp_data_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle data-memory stage between execute and writeback in the pipelined core. Accepts one load/store per handshake from execute (ALU address, rs2 data, funct3), performs an alignment check, generates word-aligned address, byte enables and lane-shifted store data for a req/gnt/rvalid data-memory port. Returns sign- or zero-extended load data, or store completion, to writeback. Drives busy_o so the hazard logic can stall fetch/decode.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width (fixed 32; byte enables are DWIDTH/8 = 4)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid_i  in  1  execute presents a memory op
req_ready_o  out  1  LSU can accept (IDLE only)
memren_i  in  1  op is load
memwren_i  in  1  op is store
funct3_i  in  3  RV32I size/sign code
addr_i  in  AWIDTH  effective byte address (ALU result)
wdata_i  in  DWIDTH  store data (rs2)
flush_i  in  1  abandon op not yet granted
mem_req_o  out  1  memory request valid
mem_we_o  out  1  1=write
mem_addr_o  out  AWIDTH  word-aligned address ({addr[31:2],2'b00})
mem_be_o  out  4  byte enables
mem_wdata_o  out  DWIDTH  lane-aligned store data
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  DWIDTH  read word
resp_valid_o  out  1  one-cycle completion pulse
resp_data_o  out  DWIDTH  extended load data (0 for stores/errors)
resp_err_o  out  1  misaligned or illegal op, valid with resp_valid_o
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; req_ready_o=1; mem_req_o, mem_we_o, resp_valid_o, resp_err_o=0; mem_addr_o, mem_be_o, mem_wdata_o, resp_data_o=0; busy_o=0.
- Accept on req_valid_i & req_ready_o; capture addr, funct3, wdata, op type into registers. req_valid_i with neither memren_i nor memwren_i is ignored (not accepted).
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE, accept, legal+aligned -> REQ; mem_req_o=1 from the next cycle (registered).
- IDLE, accept, error -> RESP with resp_err_o=1. No memory request ever issued.
- Errors: memren_i&memwren_i both set; load funct3 in {3,6,7}; store funct3 >= 3; LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
- REQ: hold mem_req_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o stable until mem_gnt_i.
  - Store gnt -> RESP.
  - Load gnt without rvalid -> WAIT_R.
  - Load gnt with rvalid in the same cycle -> RESP.
  - mem_req_o deasserts the cycle after gnt.
- WAIT_R: mem_rvalid_i -> RESP, capturing extended data.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE. resp_data_o held until the next response.
- Byte enables:
  - SB/LB/LBU: 4'b0001<<addr[1:0].
  - SH/LH/LHU: 4'b0011<<{addr[1],1'b0}.
  - SW/LW: 4'b1111.
  - Loads also drive be (informational).
- Store data: byte replicated to all four lanes; halfword replicated to both halves; word unchanged.
- Load extract: lane = mem_rdata_i >> (8*addr[1:0]).
  - LB sign-extends bit 7; LBU zero-extends.
  - LH sign-extends bit 15; LHU zero-extends.
  - LW passes through.
- flush_i:
  - In REQ before gnt (flush_i and gnt both low-then-flush): drop mem_req_o next edge, go to IDLE, no resp_valid_o.
  - flush_i in the same cycle as gnt: the grant wins and the op completes, but resp_valid_o is suppressed.
  - flush_i in WAIT_R: wait for rvalid, then return to IDLE silently.
  - flush_i in IDLE/RESP: no effect.
- mem_rvalid_i outside WAIT_R/REQ-load: ignored.
- rst mid-operation: IDLE next edge, all outputs to reset values; memory must tolerate abandoned request.
- Back-to-back throughput: minimum 3 cycles per op (accept, REQ with gnt+rvalid, RESP).

Decomposition:
- Shared package (constants.svh): FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW codes; lsu_state_e enum {IDLE,REQ,WAIT_R,RESP}; BE width constant.
- Sub-module lsu_align (combinational): funct3 + addr[1:0] + wdata/rdata -> be, lane store data, extended load data, misaligned flag.
- FSM and registers live in load_store_unit.

Test Plan:
- SW addr=0x01000104, wdata=0xDEADBEEF, gnt after 2 wait cycles -> mem_be_o=1111, mem_addr_o=0x01000104, one resp_valid_o, resp_err_o=0, req_ready_o low throughout.
- LB addr=0x01000203, mem_rdata_i=0x80123456, gnt+rvalid same cycle -> resp_data_o=0xFFFFFF80, mem_be_o=1000; LBU same -> 0x00000080.
- SH addr=0x01000002, wdata=0x0000ABCD -> mem_be_o=1100, mem_wdata_o=0xABCDABCD; LH addr=0x01000002, rdata=0x7FFF0000 -> 0x00007FFF.
- LW addr=0x01000001 -> no mem_req_o, resp_valid_o with resp_err_o=1, resp_data_o=0; funct3=3 load -> same error.
- LW, flush_i in REQ before gnt -> mem_req_o drops, no resp_valid_o, next op accepted; flush_i in WAIT_R -> rvalid consumed, no response.
- rst asserted in WAIT_R -> next cycle all outputs at reset values, req_ready_o=1; stray mem_rvalid_i afterwards ignored.
